hadamard_stream: RTL and testbench

- Parametrised, fully pipelined N-point Walsh-Hadamard transform (natural/Hadamard order); the successor to the fixed 8-point datapath.
- Accepts one vector of N signed samples per cycle over a valid/ready handshake.
- Runs LOG2N registered butterfly stages with full-precision growth and produces one transformed vector per cycle.
- Supports a per-vector inverse mode (result scaled by 1/N) and downstream backpressure.

---
 rtl/hadamard_stream_if.sv | 29 ++
 rtl/hadamard_stream.sv | 109 ++++++++++
 tb/tb_hadamard_stream.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hadamard_stream_if.sv
// Stream bundle for hadamard_stream: input vector handshake, output vector handshake and status.
// slave is the transform side, master is the producer/consumer side.
interface hadamard_stream_if #(
    parameter int unsigned N    = 8,
    parameter int unsigned IN_W = 8
);
    localparam int unsigned LOG2N = $clog2(N);
    localparam int unsigned OUT_W = IN_W + LOG2N;

    logic               in_valid;
    logic               in_ready;
    logic               inv;
    logic [N*IN_W-1:0]  x_flat;
    logic               out_valid;
    logic               out_ready;
    logic [N*OUT_W-1:0] y_flat;
    logic               out_inv;
    logic               busy;

    modport master (
        output in_valid, inv, x_flat, out_ready,
        input  in_ready, out_valid, y_flat, out_inv, busy
    );

    modport slave (
        input  in_valid, inv, x_flat, out_ready,
        output in_ready, out_valid, y_flat, out_inv, busy
    );
endinterface

// File: rtl/hadamard_stream.sv
// Fully pipelined N-point Walsh-Hadamard transform, one vector per cycle, LOG2N registered stages.
// Optional macro HADAMARD_STREAM_ROUND_EN: inverse path rounds half-up instead of flooring.
module hadamard_stream #(
    parameter int unsigned N    = 8,
    parameter int unsigned IN_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    hadamard_stream_if.slave bus
);
    localparam int unsigned LOG2N = $clog2(N);
    localparam int unsigned OUT_W = IN_W + LOG2N;

    logic             advance;
    logic             in_xfer;
    logic [LOG2N-1:0] vld_vec;

    // The whole pipeline moves as one shift register; bubbles are kept, never compressed.
    assign advance      = bus.out_ready || !bus.out_valid;
    assign in_xfer      = bus.in_valid && advance;
    assign bus.in_ready = advance;
    assign bus.busy     = |vld_vec;

    for (genvar s = 1; s <= LOG2N; s++) begin : g_stage
        localparam int unsigned IW = IN_W + s - 1;
        localparam int unsigned OW = IN_W + s;
        localparam int unsigned D  = N >> s;

        logic [N*IW-1:0] din;
        logic            vin;
        logic            iin;
        logic [N*OW-1:0] sum;
        logic [N*OW-1:0] res;
        logic [N*OW-1:0] q;
        logic            vld;
        logic            inv_q;

        if (s == 1) begin : g_src
            assign din = bus.x_flat;
            assign vin = in_xfer;
            assign iin = bus.inv;
        end else begin : g_src
            assign din = g_stage[s-1].q;
            assign vin = g_stage[s-1].vld;
            assign iin = g_stage[s-1].inv_q;
        end

        always_comb begin
            logic signed [OW-1:0] a;
            logic signed [OW-1:0] b;
            sum = '0;
            a   = '0;
            b   = '0;
            for (int unsigned k = 0; k < N; k++) begin
                if ((k & D) == 0) begin
                    a = OW'($signed(din[k*IW +: IW]));
                    b = OW'($signed(din[(k+D)*IW +: IW]));
                    sum[k*OW +: OW]     = a + b;
                    sum[(k+D)*OW +: OW] = a - b;
                end
            end
        end

        if (s == LOG2N) begin : g_out
            // Inverse scaling folds into the last register so it costs no extra cycle.
            always_comb begin
`ifdef HADAMARD_STREAM_ROUND_EN
                logic signed [OW:0] r;
                r = '0;
`endif
                res = sum;
                if (iin) begin
                    for (int unsigned k = 0; k < N; k++) begin
`ifdef HADAMARD_STREAM_ROUND_EN
                        r = $signed({sum[k*OW+OW-1], sum[k*OW +: OW]})
                            + $signed((OW+1)'(1) << (LOG2N-1));
                        res[k*OW +: OW] = OW'(r >>> LOG2N);
`else
                        res[k*OW +: OW] = $signed(sum[k*OW +: OW]) >>> LOG2N;
`endif
                    end
                end
            end
        end else begin : g_out
            assign res = sum;
        end

        // Data only loads with a valid vector, so y_flat stays 0 until the first real output.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld   <= 1'b0;
                inv_q <= 1'b0;
                q     <= '0;
            end else if (advance) begin
                vld   <= vin;
                inv_q <= vin && iin;
                if (vin) begin
                    q <= res;
                end
            end
        end

        assign vld_vec[s-1] = vld;
    end

    assign bus.out_valid = g_stage[LOG2N].vld;
    assign bus.y_flat    = g_stage[LOG2N].q;
    assign bus.out_inv   = g_stage[LOG2N].inv_q;
endmodule

// File: tb/tb_hadamard_stream.sv
// Self-checking bench for hadamard_stream: directed vector table, stall/reset sequences,
// and a randomized stream scored against a direct-sum Walsh-Hadamard model.
module tb_hadamard_stream;
    localparam int unsigned N       = 8;
    localparam int unsigned IN_W    = 8;
    localparam int unsigned LOG2N   = 3;
    localparam int unsigned OUT_W   = 11;
    localparam int unsigned B_IN_W  = 11;
    localparam int unsigned B_OUT_W = 14;
    localparam int          NT      = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   out_cnt = 0;

    always #5 clk = ~clk;

    hadamard_stream_if #(.N(N), .IN_W(IN_W))   a ();
    hadamard_stream_if #(.N(N), .IN_W(B_IN_W)) b ();

    hadamard_stream #(.N(N), .IN_W(IN_W))   dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    hadamard_stream #(.N(N), .IN_W(B_IN_W)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    typedef struct {
        int   x[N];
        logic inv;
        int   y[N];
    } vec_t;

    typedef struct {
        logic [N*OUT_W-1:0] y;
        logic               inv;
    } exp_t;

    vec_t tbl[NT];
    exp_t exp_q[$];

    task automatic check_vec(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: direct signed sum with (-1)^popcount(i&k) weights, then the inverse scaling.
    function automatic void model(input int x[N], input logic inv, output int y[N]);
        for (int k = 0; k < N; k++) begin
            int s;
            s = 0;
            for (int i = 0; i < N; i++) begin
                if (($countones(i & k) % 2) == 1) s -= x[i];
                else                              s += x[i];
            end
            if (inv) begin
`ifdef HADAMARD_STREAM_ROUND_EN
                s = (s + (1 << (LOG2N - 1))) >>> LOG2N;
`else
                s = s >>> LOG2N;
`endif
            end
            y[k] = s;
        end
    endfunction

    function automatic logic [N*OUT_W-1:0] pack_y(input int y[N]);
        logic [N*OUT_W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*OUT_W +: OUT_W] = OUT_W'(y[k]);
        return r;
    endfunction

    function automatic logic [N*IN_W-1:0] pack_x(input int x[N]);
        logic [N*IN_W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*IN_W +: IN_W] = IN_W'(x[i]);
        return r;
    endfunction

    // Scoreboard: sampled mid-cycle, exactly where the next rising edge will see the handshake.
    always @(negedge clk) begin
        exp_t e;
        int   xs[N];
        int   ys[N];
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (a.out_valid && a.out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got output %0h expected no output", a.y_flat);
                end else begin
                    e = exp_q.pop_front();
                    check_vec("sb_y", a.y_flat, e.y);
                    check_int("sb_inv", int'(a.out_inv), int'(e.inv));
                end
            end
            if (a.in_valid && a.in_ready) begin
                for (int i = 0; i < N; i++) xs[i] = int'($signed(a.x_flat[i*IN_W +: IN_W]));
                model(xs, a.inv, ys);
                e.y   = pack_y(ys);
                e.inv = a.inv;
                exp_q.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the edge that accepted the vector.
    task automatic send(input int x[N], input logic inv);
        int   t;
        logic acc;
        a.x_flat   = pack_x(x);
        a.inv      = inv;
        a.in_valid = 1'b1;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = a.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        a.in_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", t);
        end
    endtask

    logic [N*OUT_W-1:0] held;
    logic               have_held;
    int                 stall_seen;
    logic               rnd_done;

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        int   lat;
        logic seen;
        int   xv[N];
        int   base;
        logic [N*B_IN_W-1:0]  bx;
        logic [N*B_OUT_W-1:0] by;

        tbl[0].x = '{1, 1, 1, 1, 1, 1, 1, 1};          tbl[0].inv = 1'b0;
        tbl[0].y = '{8, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].x = '{127, 0, 0, 0, 0, 0, 0, 0};        tbl[1].inv = 1'b0;
        tbl[1].y = '{127, 127, 127, 127, 127, 127, 127, 127};
        tbl[2].x = '{-128, -128, -128, -128, -128, -128, -128, -128}; tbl[2].inv = 1'b0;
        tbl[2].y = '{-1024, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].x = '{1, 2, 3, 4, 5, 6, 7, 8};          tbl[3].inv = 1'b0;
        tbl[3].y = '{36, -4, -8, 0, -16, 0, 0, 0};
        tbl[4].x = '{4, 0, 0, 0, 0, 0, 0, 0};          tbl[4].inv = 1'b1;
        tbl[5].x = '{-4, 0, 0, 0, 0, 0, 0, 0};         tbl[5].inv = 1'b1;
        tbl[6].x = '{1, 2, 3, 4, 5, 6, 7, 8};          tbl[6].inv = 1'b1;
`ifdef HADAMARD_STREAM_ROUND_EN
        tbl[4].y = '{1, 1, 1, 1, 1, 1, 1, 1};
        tbl[5].y = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6].y = '{5, 0, -1, 0, -2, 0, 0, 0};
`else
        tbl[4].y = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5].y = '{-1, -1, -1, -1, -1, -1, -1, -1};
        tbl[6].y = '{4, -1, -1, 0, -2, 0, 0, 0};
`endif

        a.in_valid = 1'b0; a.inv = 1'b0; a.x_flat = '0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.inv = 1'b0; b.x_flat = '0; b.out_ready = 1'b1;
        have_held = 1'b0; stall_seen = 0; rnd_done = 1'b0; held = '0;

        #2 rst_n = 1'b0;
        #1;
        check_int("rst_out_valid", int'(a.out_valid), 0);
        check_int("rst_busy", int'(a.busy), 0);
        check_int("rst_in_ready", int'(a.in_ready), 1);
        check_int("rst_out_inv", int'(a.out_inv), 0);
        check_vec("rst_y", a.y_flat, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: latency, values, one-cycle output pulse.
        for (int t = 0; t < NT; t++) begin
            send(tbl[t].x, tbl[t].inv);
            lat  = 1;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (a.out_valid) seen = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
            if (!seen) begin
                tests++;
                fails++;
                $display("FAIL tbl%0d_timeout: got out_valid=0 expected 1 within 10 cycles", t);
            end else begin
                check_int($sformatf("tbl%0d_latency", t), lat, LOG2N);
                check_vec($sformatf("tbl%0d_y", t), a.y_flat, pack_y(tbl[t].y));
                check_int($sformatf("tbl%0d_inv", t), int'(a.out_inv), int'(tbl[t].inv));
            end
            @(posedge clk);
            #1;
            check_int($sformatf("tbl%0d_pulse", t), int'(a.out_valid), 0);
        end

        // Round trip at IN_W=11: inverse of the forward result recovers 1..8.
        xv = '{36, -4, -8, 0, -16, 0, 0, 0};
        for (int i = 0; i < N; i++) bx[i*B_IN_W +: B_IN_W] = B_IN_W'(xv[i]);
        for (int k = 0; k < N; k++) by[k*B_OUT_W +: B_OUT_W] = B_OUT_W'(k + 1);
        b.x_flat = bx; b.inv = 1'b1; b.in_valid = 1'b1;
        @(posedge clk);
        #1 b.in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (b.out_valid) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL inv_roundtrip_timeout: got out_valid=0 expected 1 within 10 cycles");
        end else begin
            check_vec("inv_roundtrip_y", b.y_flat, by);
            check_int("inv_roundtrip_inv", int'(b.out_inv), 1);
        end
        @(posedge clk);
        #1;

        // Continuous stream of 6 vectors with out_ready low for 4 cycles mid-stream.
        base = out_cnt;
        fork
            begin
                for (int v = 1; v <= 6; v++) begin
                    for (int i = 0; i < N; i++) xv[i] = v * 10 + i;
                    send(xv, logic'(v % 2));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 a.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 a.out_ready = 1'b1;
            end
            begin
                repeat (14) begin
                    @(negedge clk);
                    if (!a.out_ready && a.out_valid) begin
                        check_int("stall_in_ready", int'(a.in_ready), 0);
                        if (have_held) check_vec("stall_hold", a.y_flat, held);
                        held = a.y_flat;
                        have_held = 1'b1;
                        stall_seen++;
                    end
                end
            end
        join
        check_int("stall_cycles", stall_seen, 4);
        for (int c = 0; c < 30 && out_cnt < base + 6; c++) @(posedge clk);
        #1;
        check_int("stall_count", out_cnt - base, 6);

        // Randomized stream with random gaps and random backpressure.
        fork
            begin
                for (int v = 0; v < 200; v++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    for (int i = 0; i < N; i++) begin
                        if ($urandom_range(0, 7) == 0) xv[i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
                        else                           xv[i] = int'($urandom_range(0, 255)) - 128;
                    end
                    send(xv, logic'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 a.out_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        a.out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check_int("rand_drain", exp_q.size(), 0);

        // Reset while two vectors are in flight and the output is stalled.
        @(posedge clk);
        #1 a.out_ready = 1'b0;
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < N; i++) xv[i] = 50 + v;
            send(xv, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        check_int("pre_rst_out_valid", int'(a.out_valid), 1);
        check_int("pre_rst_busy", int'(a.busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_int("midrst_out_valid", int'(a.out_valid), 0);
        check_int("midrst_busy", int'(a.busy), 0);
        check_vec("midrst_y", a.y_flat, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_int("postrst_in_ready", int'(a.in_ready), 1);
        base = out_cnt;
        a.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_int("postrst_no_stale", out_cnt - base, 0);
        check_int("postrst_busy", int'(a.busy), 0);
        check_int("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
